// File: rtl/bus_pkg.sv
// Shared definitions for the external memory bus arbiter.
// Bus widths, strobe constants and arbiter state encoding.
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;
  localparam int STRB_W = 4;

  localparam logic [STRB_W-1:0] STRB_NONE = 4'b0000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_F = 2'd1;
  localparam logic [1:0] ST_BUSY_M = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    BUSY_F = ST_BUSY_F,
    BUSY_M = ST_BUSY_M
  } state_t;

  function automatic logic [BUS_AW-1:0] word_align(
    input logic [BUS_AW-1:0] a
  );
    return {a[BUS_AW-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Fetch, load/store and external bus signals of the arbiter.
// slave = arbiter side, master = requesters plus external memory.
interface bus_arbiter_if;
  import bus_pkg::*;

  logic              fetch_valid;
  logic [BUS_AW-1:0] fetch_address;
  logic [BUS_DW-1:0] fetch_data;
  logic              fetch_ready;
  logic              fetch_error;

  logic              mem_valid;
  logic [BUS_AW-1:0] mem_address;
  logic [BUS_DW-1:0] mem_write_data;
  logic [STRB_W-1:0] mem_write_strobe;
  logic [BUS_DW-1:0] mem_read_data;
  logic              mem_ready;
  logic              mem_error;

  logic              ext_valid;
  logic              ext_instruction;
  logic [BUS_AW-1:0] ext_address;
  logic [BUS_DW-1:0] ext_write_data;
  logic [STRB_W-1:0] ext_write_strobe;
  logic              ext_ready;
  logic [BUS_DW-1:0] ext_read_data;

  modport slave (
    input  fetch_valid, fetch_address,
    output fetch_data, fetch_ready, fetch_error,
    input  mem_valid, mem_address,
    input  mem_write_data, mem_write_strobe,
    output mem_read_data, mem_ready, mem_error,
    output ext_valid, ext_instruction,
    output ext_address, ext_write_data,
    output ext_write_strobe,
    input  ext_ready, ext_read_data
  );

  modport master (
    output fetch_valid, fetch_address,
    input  fetch_data, fetch_ready, fetch_error,
    output mem_valid, mem_address,
    output mem_write_data, mem_write_strobe,
    input  mem_read_data, mem_ready, mem_error,
    input  ext_valid, ext_instruction,
    input  ext_address, ext_write_data,
    input  ext_write_strobe,
    output ext_ready, ext_read_data
  );

endinterface

// File: rtl/bus_watchdog.sv
// Busy-cycle counter that flags a stalled external transfer.
// TIMEOUT_CYCLES = 0 keeps the counter idle and never expires.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && ENABLED) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires in the last stalled cycle so the abort lands on its edge.
  assign expired = ENABLED && enable && (cnt == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Registered fetch / load-store arbiter for the external bus,
// with fetch-starvation protection and a bus timeout.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int MEM_STREAK_MAX = 4,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic clk,
  input  logic reset_n,
  bus_arbiter_if.slave bus
);

  localparam int SW = $clog2(MEM_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_TOP = SW'(MEM_STREAK_MAX);

  state_t state, state_nx;

  logic [SW-1:0] streak;
  logic          idle;
  logic          fetch_cand;
  logic          mem_cand;
  logic          grant_m;
  logic          grant_f;
  logic          done;
  logic          expire;

  logic              ext_valid_q;
  logic              ext_instr_q;
  logic [BUS_AW-1:0] ext_addr_q;
  logic [BUS_DW-1:0] ext_wdata_q;
  logic [STRB_W-1:0] ext_strb_q;

  logic              f_rdy_q, f_err_q;
  logic              m_rdy_q, m_err_q;
  logic [BUS_DW-1:0] f_data_q, m_data_q;

  // A port still showing its response pulse sits out this grant.
  assign idle       = (state == IDLE);
  assign fetch_cand = bus.fetch_valid && !f_rdy_q && !f_err_q;
  assign mem_cand   = bus.mem_valid && !m_rdy_q && !m_err_q;
  assign grant_m    = idle && mem_cand &&
                      !(fetch_cand && streak == STREAK_TOP);
  assign grant_f    = idle && fetch_cand && !grant_m;
  assign done       = !idle && bus.ext_ready;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_wdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (grant_m || grant_f),
    .enable (!idle && !bus.ext_ready),
    .expired(expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      grant_m:         state_nx = BUSY_M;
      grant_f:         state_nx = BUSY_F;
      done || expire:  state_nx = IDLE;
      default:         state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak <= '0;
    end else if (grant_m) begin
      if (streak != STREAK_TOP) begin
        streak <= streak + 1'b1;
      end
    end else if (grant_f) begin
      streak <= '0;
    end else if (idle && !bus.fetch_valid) begin
      streak <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_valid_q <= 1'b0;
      ext_instr_q <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      ext_strb_q  <= STRB_NONE;
    end else if (grant_m) begin
      ext_valid_q <= 1'b1;
      ext_instr_q <= 1'b0;
      ext_addr_q  <= word_align(bus.mem_address);
      ext_wdata_q <= bus.mem_write_data;
      ext_strb_q  <= bus.mem_write_strobe;
    end else if (grant_f) begin
      ext_valid_q <= 1'b1;
      ext_instr_q <= 1'b1;
      ext_addr_q  <= word_align(bus.fetch_address);
      ext_wdata_q <= '0;
      ext_strb_q  <= STRB_NONE;
    end else if (done || expire) begin
      ext_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_rdy_q  <= 1'b0;
      f_err_q  <= 1'b0;
      f_data_q <= '0;
      m_rdy_q  <= 1'b0;
      m_err_q  <= 1'b0;
      m_data_q <= '0;
    end else begin
      f_rdy_q  <= done && state == BUSY_F;
      f_err_q  <= expire && state == BUSY_F;
      f_data_q <= (done && state == BUSY_F) ?
                  bus.ext_read_data : '0;
      m_rdy_q  <= done && state == BUSY_M;
      m_err_q  <= expire && state == BUSY_M;
      m_data_q <= (done && state == BUSY_M) ?
                  bus.ext_read_data : '0;
    end
  end

  assign bus.fetch_ready      = f_rdy_q;
  assign bus.fetch_error      = f_err_q;
  assign bus.fetch_data       = f_data_q;
  assign bus.mem_ready        = m_rdy_q;
  assign bus.mem_error        = m_err_q;
  assign bus.mem_read_data    = m_data_q;
  assign bus.ext_valid        = ext_valid_q;
  assign bus.ext_instruction  = ext_instr_q;
  assign bus.ext_address      = ext_addr_q;
  assign bus.ext_write_data   = ext_wdata_q;
  assign bus.ext_write_strobe = ext_strb_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Random-stimulus bench for bus_arbiter with a scoreboard fed
// by a transfer-level reference model.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int MAXS = 4;
  localparam int TO   = 8;

  typedef struct {
    int          cyc;
    bit          instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } xfer_t;

  typedef struct {
    int          cyc;
    bit          rdy;
    bit          err;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if bus();

  bus_arbiter #(
    .MEM_STREAK_MAX(MAXS),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  xfer_t xq[$];
  resp_t fq[$];
  resp_t mq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int p_f = 0, p_m = 0, p_rdy = 0;
  bit run_req = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: one transfer at a time, decided from the
  // arbitration rules on the sampled request inputs.
  bit    m_busy, m_isf, f_pend, m_pend, fp, mp;
  bit    fc, mc, gm, gf;
  int    m_cnt, m_streak;
  xfer_t nx;
  resp_t nr;

  initial begin
    m_busy = 0; m_isf = 0; f_pend = 0; m_pend = 0;
    m_cnt = 0; m_streak = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        m_busy = 0; f_pend = 0; m_pend = 0;
        m_cnt = 0; m_streak = 0;
      end else begin
        fp = f_pend; mp = m_pend;
        f_pend = 0; m_pend = 0;
        if (!m_busy) begin
          fc = bus.fetch_valid && !fp;
          mc = bus.mem_valid && !mp;
          gm = mc && !(fc && m_streak == MAXS);
          gf = fc && !gm;
          if (gm) begin
            m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            nx.cyc = cyc; nx.instr = 0;
            nx.addr = bus.mem_address & 32'hFFFF_FFFC;
            nx.wdata = bus.mem_write_data;
            nx.strb = bus.mem_write_strobe;
            xq.push_back(nx);
            m_busy = 1; m_isf = 0; m_cnt = 0;
          end else if (gf) begin
            m_streak = 0;
            nx.cyc = cyc; nx.instr = 1;
            nx.addr = bus.fetch_address & 32'hFFFF_FFFC;
            nx.wdata = 0; nx.strb = 0;
            xq.push_back(nx);
            m_busy = 1; m_isf = 1; m_cnt = 0;
          end else if (!bus.fetch_valid) begin
            m_streak = 0;
          end
        end else begin
          nr.cyc = cyc;
          if (bus.ext_ready) begin
            nr.rdy = 1; nr.err = 0; nr.data = bus.ext_read_data;
            m_busy = 0;
          end else begin
            m_cnt++;
            nr.rdy = 0; nr.err = 1; nr.data = 0;
            if (m_cnt == TO) m_busy = 0;
          end
          if (!m_busy) begin
            if (m_isf) begin fq.push_back(nr); f_pend = 1; end
            else begin mq.push_back(nr); m_pend = 1; end
          end
        end
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the queues.
  bit    prev_ev = 0;
  xfer_t ax;
  resp_t ar;

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("ext_valid", bus.ext_valid, m_busy);
      if (bus.ext_valid && !prev_ev) begin
        if (xq.size() == 0) begin
          chk("ext_unexpected", 1, 0);
        end else begin
          ax = xq.pop_front();
          chk("ext_cycle", ax.cyc, cyc);
          chk("ext_instruction", bus.ext_instruction, ax.instr);
          chk("ext_address", bus.ext_address, ax.addr);
          chk("ext_strobe", bus.ext_write_strobe, ax.strb);
          if (!ax.instr) chk("ext_wdata", bus.ext_write_data, ax.wdata);
        end
      end else if (xq.size() != 0 && xq[0].cyc < cyc) begin
        chk("ext_missing", 0, 1);
        void'(xq.pop_front());
      end
      prev_ev = bus.ext_valid;

      if (bus.fetch_ready || bus.fetch_error) begin
        if (fq.size() == 0) begin
          chk("fetch_unexpected",
              {bus.fetch_ready, bus.fetch_error}, 0);
        end else begin
          ar = fq.pop_front();
          chk("fetch_cycle", cyc, ar.cyc);
          chk("fetch_flags", {bus.fetch_ready, bus.fetch_error},
              {ar.rdy, ar.err});
          chk("fetch_data", bus.fetch_data, ar.data);
        end
      end else begin
        chk("fetch_data_quiet", bus.fetch_data, 0);
        if (fq.size() != 0 && fq[0].cyc < cyc) begin
          chk("fetch_missing", 0, 1);
          void'(fq.pop_front());
        end
      end

      if (bus.mem_ready || bus.mem_error) begin
        if (mq.size() == 0) begin
          chk("mem_unexpected", {bus.mem_ready, bus.mem_error}, 0);
        end else begin
          ar = mq.pop_front();
          chk("mem_cycle", cyc, ar.cyc);
          chk("mem_flags", {bus.mem_ready, bus.mem_error},
              {ar.rdy, ar.err});
          chk("mem_data", bus.mem_read_data, ar.data);
        end
      end else begin
        chk("mem_data_quiet", bus.mem_read_data, 0);
        if (mq.size() != 0 && mq[0].cyc < cyc) begin
          chk("mem_missing", 0, 1);
          void'(mq.pop_front());
        end
      end
    end else begin
      prev_ev = 0;
    end
  end

  // Requesters hold each request until its response pulse.
  initial begin
    bus.fetch_valid = 0;
    bus.fetch_address = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bus.fetch_valid = 0;
      end else if (bus.fetch_valid) begin
        if (bus.fetch_ready || bus.fetch_error) begin
          bus.fetch_valid = run_req && ($urandom % 100 < p_f);
          bus.fetch_address = $urandom;
        end
      end else if (run_req && ($urandom % 100 < p_f)) begin
        bus.fetch_valid = 1;
        bus.fetch_address = $urandom;
      end
    end
  end

  task automatic new_mem();
    bus.mem_address = $urandom;
    bus.mem_write_data = $urandom;
    bus.mem_write_strobe = ($urandom % 2) ? 4'($urandom) : 4'b0;
  endtask

  initial begin
    bus.mem_valid = 0;
    bus.mem_address = 0;
    bus.mem_write_data = 0;
    bus.mem_write_strobe = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        bus.mem_valid = 0;
      end else if (bus.mem_valid) begin
        if (bus.mem_ready || bus.mem_error) begin
          bus.mem_valid = run_req && ($urandom % 100 < p_m);
          new_mem();
        end
      end else if (run_req && ($urandom % 100 < p_m)) begin
        bus.mem_valid = 1;
        new_mem();
      end
    end
  end

  // External memory: random ready, also while the bus is idle.
  initial begin
    bus.ext_ready = 0;
    bus.ext_read_data = 0;
    forever begin
      @(negedge clk);
      bus.ext_ready = ($urandom % 100 < p_rdy);
      bus.ext_read_data = $urandom;
    end
  end

  task automatic chk_all_zero(string name);
    chk(name, |{bus.fetch_data, bus.fetch_ready, bus.fetch_error,
                bus.mem_read_data, bus.mem_ready, bus.mem_error,
                bus.ext_valid, bus.ext_instruction,
                bus.ext_address, bus.ext_write_data,
                bus.ext_write_strobe}, 0);
  endtask

  task automatic run_phase(int f, int m, int r, int n);
    p_f = f; p_m = m; p_rdy = r;
    repeat (n) @(negedge clk);
  endtask

  bit found;

  initial begin
    #1 reset_n = 0;
    #2 chk_all_zero("reset_outputs");
    repeat (3) @(negedge clk);
    #2 reset_n = 1;
    run_req = 1;

    run_phase(50, 50, 60, 400);
    run_phase(40, 60, 8, 300);
    run_phase(100, 100, 100, 200);
    run_phase(30, 30, 30, 200);

    // Abort an in-flight load/store with reset.
    p_f = 0; p_m = 100; p_rdy = 0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = m_busy && !m_isf;
    end
    chk("busy_m_reached", found, 1);
    #2 reset_n = 0;
    #1 chk_all_zero("async_reset_outputs");
    chk("queues_at_reset", xq.size() + fq.size() + mq.size(), 0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1;
    run_phase(50, 50, 50, 200);

    run_req = 0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = !m_busy && !bus.fetch_valid && !bus.mem_valid &&
              xq.size() == 0 && fq.size() == 0 && mq.size() == 0;
    end
    repeat (3) @(negedge clk);
    chk("drained", found, 1);
    chk("queues_empty", xq.size() + fq.size() + mq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
